// File: rtl/y_demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | y_demux_pkg : shared encodings for the y_stream_demux block        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package y_demux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_e;

   localparam int   DEPTH = 2;
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/y_skid_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | y_skid_fifo2 : 2-entry output buffer with registered head word     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module y_skid_fifo2
   import y_demux_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] data,
   output logic         valid,
   output logic         full
);

   buf_state_e   r_state;
   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic         r_valid;
   logic         r_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= 1'b0;
         r_full  <= 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (push) begin
                  r_head  <= push_data;
                  r_state <= ONE;
                  r_valid <= 1'b1;
               end
            end
            ONE: begin
               if (push && pop) begin
                  r_head <= push_data;
               end else if (push) begin
                  r_tail  <= push_data;
                  r_state <= TWO;
                  r_full  <= 1'b1;
               end else if (pop) begin
                  r_state <= EMPTY;
                  r_valid <= 1'b0;
               end
            end
            TWO: begin
               // Upstream ready is low while full, so only a pop can occur here.
               if (pop) begin
                  r_head  <= r_tail;
                  r_state <= ONE;
                  r_full  <= 1'b0;
               end
            end
            default: begin
               r_state <= EMPTY;
               r_valid <= 1'b0;
               r_full  <= 1'b0;
            end
         endcase
      end
   end

   assign data  = r_head;
   assign valid = r_valid;
   assign full  = r_full;

endmodule
`default_nettype wire

// File: rtl/y_stream_demux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | y_stream_demux : 1-to-2 valid/ready demux with per-port counters   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module y_stream_demux
   import y_demux_pkg::*;
#(
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  in_data,
   input  logic          in_sel,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  a_data,
   output logic          a_valid,
   input  logic          a_ready,
   output logic [W-1:0]  b_data,
   output logic          b_valid,
   input  logic          b_ready,
   output logic [CW-1:0] a_count,
   output logic [CW-1:0] b_count
);

   logic          w_a_full;
   logic          w_b_full;
   logic          w_accept;
   logic          w_push_a;
   logic          w_push_b;
   logic          w_pop_a;
   logic          w_pop_b;
   logic [CW-1:0] r_a_count;
   logic [CW-1:0] r_b_count;

   // Ready only looks at the targeted port, so a stalled port never blocks the other.
   assign in_ready = !rst && ((in_sel == SEL_B) ? !w_b_full : !w_a_full);
   assign w_accept = in_valid && in_ready;
   assign w_push_a = w_accept && (in_sel == SEL_A);
   assign w_push_b = w_accept && (in_sel == SEL_B);
   assign w_pop_a  = a_valid && a_ready;
   assign w_pop_b  = b_valid && b_ready;

   y_skid_fifo2 #(.W(W)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_a),
      .push_data (in_data),
      .pop       (w_pop_a),
      .data      (a_data),
      .valid     (a_valid),
      .full      (w_a_full)
   );

   y_skid_fifo2 #(.W(W)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_b),
      .push_data (in_data),
      .pop       (w_pop_b),
      .data      (b_data),
      .valid     (b_valid),
      .full      (w_b_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_count <= '0;
         r_b_count <= '0;
      end else begin
         if (w_pop_a) r_a_count <= r_a_count + CW'(1);
         if (w_pop_b) r_b_count <= r_b_count + CW'(1);
      end
   end

   assign a_count = r_a_count;
   assign b_count = r_b_count;

endmodule
`default_nettype wire

// File: tb/tb_y_stream_demux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_y_stream_demux : randomized bench with per-port queue model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_y_stream_demux;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_data;
   logic        a_valid;
   logic        a_ready;
   logic [31:0] b_data;
   logic        b_valid;
   logic        b_ready;
   logic [15:0] a_count;
   logic [15:0] b_count;

   y_stream_demux #(.W(32), .CW(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .a_count  (a_count),
      .b_count  (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [15:0] ca = '0;
   logic [15:0] cb = '0;
   logic        last_acc = 1'b0;
   int          acc_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: compare DUT to the queue model mid-cycle, then advance the model.
   task automatic step();
      logic exp_rdy;
      @(negedge clk);
      exp_rdy = !rst && (in_sel ? (qb.size() < 2) : (qa.size() < 2));
      check("in_ready", in_ready, exp_rdy);
      check("a_valid", a_valid, qa.size() != 0);
      check("b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) check("a_data", a_data, qa[0]);
      if (qb.size() != 0) check("b_data", b_data, qb[0]);
      check("a_count", a_count, ca);
      check("b_count", b_count, cb);
      last_acc = in_valid && exp_rdy;
      if (rst) begin
         qa.delete();
         qb.delete();
         ca = '0;
         cb = '0;
      end else begin
         if (qa.size() != 0 && a_ready) begin
            void'(qa.pop_front());
            ca = ca + 16'd1;
         end
         if (qb.size() != 0 && b_ready) begin
            void'(qb.pop_front());
            cb = cb + 16'd1;
         end
         if (last_acc) begin
            acc_total++;
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      in_data  = 32'h0;
      in_sel   = 1'b0;
      in_valid = 1'b1;
      a_ready  = 1'b1;
      b_ready  = 1'b1;

      // Reset with a word offered
      step();
      step();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_a_data", a_data, 32'h0);
      check("rst_b_data", b_data, 32'h0);
      check("rst_a_valid", a_valid, 1'b0);
      check("rst_counts", {a_count, b_count}, 32'h0);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();

      // Basic routing
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
      step();
      check("route_a_valid", a_valid, 1'b1);
      check("route_a_data", a_data, 32'hDEADBEEF);
      in_sel = 1'b1; in_data = 32'h12345678;
      step();
      check("route_b_data", b_data, 32'h12345678);
      in_valid = 1'b0;
      step();
      step();
      check("route_a_count", a_count, 16'd1);
      check("route_b_count", b_count, 16'd1);

      // Backpressure on A, isolation of B
      a_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1;
      step();
      in_data = 32'h2;
      step();
      in_valid = 1'b0; in_sel = 1'b0;
      #1;
      check("a_full_block", in_ready, 1'b0);
      in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hB0;
      #1;
      check("b_open", in_ready, 1'b1);
      step();
      check("iso_b_data", b_data, 32'hB0);
      check("iso_a_head", a_data, 32'h1);
      in_valid = 1'b0;
      a_ready = 1'b1;
      step();
      check("drain_a_second", a_data, 32'h2);
      repeat (3) step();

      // Full throughput
      acc_total = 0;
      begin
         logic [15:0] base;
         base = a_count + b_count;
         for (int i = 0; i < 500; i++) begin
            in_valid = 1'b1;
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            step();
         end
         in_valid = 1'b0;
         repeat (3) step();
         check("tput_accepts", acc_total, 500);
         check("tput_sum", 16'(a_count + b_count - base), 16'd500);
      end

      // Randomized traffic with backpressure; offered words held until taken
      for (int i = 0; i < 800; i++) begin
         if (!(in_valid && !last_acc)) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = $urandom;
         end
         a_ready = ($urandom_range(0, 3) != 0);
         b_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      repeat (4) step();

      // Counter wrap on B
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hA000 + 32'(i);
         step();
      end
      in_sel = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         in_data = 32'(i);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      check("wrap_b_count", b_count, 16'h0000);
      check("wrap_a_count", a_count, 16'd3);

      // Mid-stream reset discards buffered words
      a_ready = 1'b0; b_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA1;
      step();
      in_data = 32'hA2;
      step();
      in_sel = 1'b1; in_data = 32'hB1;
      step();
      in_valid = 1'b0;
      check("pre_rst_a_full", {a_valid, b_valid}, 2'b11);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", {a_valid, b_valid}, 2'b00);
      check("mid_rst_counts", {a_count, b_count}, 32'h0);
      check("mid_rst_data", {a_data, b_data}, 64'h0);
      a_ready = 1'b1; b_ready = 1'b1;
      repeat (5) step();
      check("post_rst_counts", {a_count, b_count}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
